// File: rtl/btn_scan_scheduler_if.sv
// Press-event handshake between btn_scan_scheduler (master) and its consumer (slave).
// The scheduler drives event_valid/event_id; the consumer answers with event_ready.
interface btn_scan_scheduler_if #(
    parameter int ID_W = 2
);
    logic            event_valid;
    logic [ID_W-1:0] event_id;
    logic            event_ready;

    modport master (output event_valid, output event_id, input event_ready);
    modport slave  (input event_valid, input event_id, output event_ready);
endinterface

// File: rtl/btn_scan_scheduler.sv
// Debounces NUM_BTN push-buttons with one shared settle counter, granted round-robin.
// Optional macro BTN_AUTOREPEAT_EN re-emits the event while the granted button stays held.
module btn_scan_scheduler #(
    parameter int NUM_BTN       = 4,
    parameter int SETTLE_CYCLES = 5000000,
    parameter int CNT_W         = 26,
    parameter int ID_W          = 2
`ifdef BTN_AUTOREPEAT_EN
   ,parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [NUM_BTN-1:0]   button_in,
    btn_scan_scheduler_if.master evt,
    output logic                 busy,
    output logic [NUM_BTN-1:0]   sel_onehot
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_EMIT, ST_RELEASE} state_e;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic [ID_W-1:0]    lastGrant_q, lastGrant_d;
    logic               eventValid_q, eventValid_d;
    logic [ID_W-1:0]    eventId_q, eventId_d;
    logic [NUM_BTN-1:0] btnMeta_q, btnS_q;

    logic [NUM_BTN-1:0] selOneHot;
    logic               selBit;
    logic               grantFound;
    logic [ID_W-1:0]    grantIdx;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            btnMeta_q <= '0;
            btnS_q    <= '0;
        end else begin
            btnMeta_q <= button_in;
            btnS_q    <= btnMeta_q;
        end
    end

    always_comb begin
        selOneHot = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            selOneHot[i] = (state_q != ST_IDLE) && (sel_q == ID_W'(i));
        end
        selBit = |(btnS_q & selOneHot);
    end

    // Lowest pressed index above lastGrant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int j = NUM_BTN - 1; j >= 0; j--) begin
            if (btnS_q[j] && (j <= int'(lastGrant_q))) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(j);
            end
        end
        for (int j = NUM_BTN - 1; j >= 0; j--) begin
            if (btnS_q[j] && (j > int'(lastGrant_q))) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            lastGrant_q  <= ID_W'(NUM_BTN - 1);
            eventValid_q <= 1'b0;
            eventId_q    <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            lastGrant_q  <= lastGrant_d;
            eventValid_q <= eventValid_d;
            eventId_q    <= eventId_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q        <= rpt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        lastGrant_d  = lastGrant_q;
        eventValid_d = eventValid_q;
        eventId_d    = eventId_q;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d        = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grantFound) begin
                    sel_d       = grantIdx;
                    lastGrant_d = grantIdx;
                    cnt_d       = '0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!selBit) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d      = ST_EMIT;
                    eventValid_d = 1'b1;
                    eventId_d    = sel_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (eventValid_q && evt.event_ready) begin
                    eventValid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (selBit) begin
                    cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
                    if (rpt_q == REPEAT_LAST) begin
                        state_d      = ST_EMIT;
                        eventValid_d = 1'b1;
                        eventId_d    = sel_q;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
`endif
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign evt.event_valid = eventValid_q;
    assign evt.event_id    = eventId_q;
    assign busy            = (state_q != ST_IDLE);
    assign sel_onehot      = selOneHot;

endmodule

// File: tb/tb_btn_scan_scheduler.sv
// Directed testbench for btn_scan_scheduler with SETTLE_CYCLES=4, NUM_BTN=4.
// Expected values are hand-derived edge counts from the raw button change.
module tb_btn_scan_scheduler;

    localparam int NUM_BTN = 4;
    localparam int ID_W    = 2;

    logic               clk_in;
    logic               reset;
    logic [NUM_BTN-1:0] button_in;
    logic               busy;
    logic [NUM_BTN-1:0] sel_onehot;

    int vectorCount = 0;
    int missCount   = 0;

    btn_scan_scheduler_if #(.ID_W(ID_W)) evtIf ();

    btn_scan_scheduler #(
        .NUM_BTN      (NUM_BTN),
        .SETTLE_CYCLES(4),
        .CNT_W        (3),
        .ID_W         (ID_W)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .button_in (button_in),
        .evt       (evtIf.master),
        .busy      (busy),
        .sel_onehot(sel_onehot)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic tickN(input int n);
        repeat (n) tick();
    endtask

    task automatic waitForValid(input string tag);
        int n = 0;
        while (!evtIf.event_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(evtIf.event_valid), 32'd1);
    endtask

    task automatic waitForIdle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus();
        int seen;
        int expIds [5] = '{0, 1, 2, 3, 0};

        reset = 1'b0;
        button_in = '0;
        evtIf.event_ready = 1'b0;
        #2 reset = 1'b1;
        tickN(2);
        checkOutput("rst_valid", 32'(evtIf.event_valid), 32'd0);
        checkOutput("rst_id",    32'(evtIf.event_id),    32'd0);
        checkOutput("rst_busy",  32'(busy),              32'd0);
        checkOutput("rst_sel",   32'(sel_onehot),        32'd0);
        reset = 1'b0;
        tickN(2);

        // Single press of button 1 with the consumer always ready.
        button_in = 4'b0010;
        evtIf.event_ready = 1'b1;
        tickN(2);
        checkOutput("t1_idle_during_sync", 32'(busy), 32'd0);
        tick();
        checkOutput("t1_busy_on_grant", 32'(busy), 32'd1);
        checkOutput("t1_sel_on_grant",  32'(sel_onehot), 32'b0010);
        tickN(3);
        checkOutput("t1_valid_edge6", 32'(evtIf.event_valid), 32'd0);
        tick();
        checkOutput("t1_valid_edge7", 32'(evtIf.event_valid), 32'd1);
        checkOutput("t1_id",          32'(evtIf.event_id),    32'd1);
        tick();
        checkOutput("t1_valid_edge8", 32'(evtIf.event_valid), 32'd0);
        seen = 0;
        repeat (12) begin
            tick();
            if (evtIf.event_valid) seen++;
        end
        checkOutput("t1_single_event", 32'(seen), 32'd0);
        button_in = '0;
        tickN(5);
        checkOutput("t1_busy_before_release", 32'(busy), 32'd1);
        tick();
        checkOutput("t1_idle_after_release", 32'(busy), 32'd0);
        checkOutput("t1_sel_idle", 32'(sel_onehot), 32'd0);

        // Short glitch on button 0 must be rejected.
        tickN(2);
        seen = 0;
        button_in = 4'b0001;
        tickN(3);
        button_in = '0;
        tickN(2);
        checkOutput("t2_busy_mid_glitch", 32'(busy), 32'd1);
        tick();
        checkOutput("t2_idle_after_glitch", 32'(busy), 32'd0);
        checkOutput("t2_sel_zero", 32'(sel_onehot), 32'd0);
        repeat (6) begin
            if (evtIf.event_valid) seen++;
            tick();
        end
        checkOutput("t2_no_event", 32'(seen), 32'd0);

        // Backpressure on button 2.
        evtIf.event_ready = 1'b0;
        button_in = 4'b0100;
        tickN(7);
        checkOutput("t3_valid", 32'(evtIf.event_valid), 32'd1);
        checkOutput("t3_id",    32'(evtIf.event_id),    32'd2);
        seen = 0;
        repeat (10) begin
            tick();
            if (evtIf.event_valid && evtIf.event_id == 2'd2) seen++;
        end
        checkOutput("t3_held_cycles", 32'(seen), 32'd10);
        evtIf.event_ready = 1'b1;
        tick();
        checkOutput("t3_transfer", 32'(evtIf.event_valid), 32'd0);
        seen = 0;
        repeat (8) begin
            tick();
            if (evtIf.event_valid) seen++;
        end
        checkOutput("t3_one_transfer", 32'(seen), 32'd0);
        button_in = '0;
        waitForIdle("t3_idle_timeout");

        // Round-robin order from a fresh reset with all buttons pressed together.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int r = 0; r < 5; r++) begin
            button_in = 4'b1111;
            waitForValid($sformatf("t4_valid_timeout_%0d", r));
            checkOutput($sformatf("t4_id_%0d", r), 32'(evtIf.event_id), 32'(expIds[r]));
            tick();
            button_in = '0;
            waitForIdle($sformatf("t4_idle_timeout_%0d", r));
            tickN(2);
        end

        // Release bounce on button 3 keeps the scheduler busy.
        button_in = 4'b1000;
        waitForValid("t5_valid_timeout");
        checkOutput("t5_id", 32'(evtIf.event_id), 32'd3);
        tick();
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            button_in = ((c / 2) % 2 == 1) ? 4'b1000 : 4'b0000;
            tick();
            if (!busy) seen++;
        end
        button_in = '0;
        repeat (5) begin
            tick();
            if (!busy) seen++;
        end
        checkOutput("t5_busy_through_bounce", 32'(seen), 32'd0);
        tick();
        checkOutput("t5_idle_after_4_low", 32'(busy), 32'd0);

        // Asynchronous reset while an event is pending.
        evtIf.event_ready = 1'b0;
        button_in = 4'b0001;
        waitForValid("t6_valid_timeout");
        checkOutput("t6_id_before_reset", 32'(evtIf.event_id), 32'd0);
        #3 reset = 1'b1;
        #1;
        checkOutput("t6_valid_async_clear", 32'(evtIf.event_valid), 32'd0);
        checkOutput("t6_busy_async_clear",  32'(busy),              32'd0);
        evtIf.event_ready = 1'b1;
        tickN(2);
        reset = 1'b0;
        tickN(6);
        checkOutput("t6_requalify_edge6", 32'(evtIf.event_valid), 32'd0);
        tick();
        checkOutput("t6_requalify_edge7", 32'(evtIf.event_valid), 32'd1);
        checkOutput("t6_requalify_id",    32'(evtIf.event_id),    32'd0);
        tick();
        button_in = '0;
        waitForIdle("t6_idle_timeout");
    endtask

    initial begin
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
